// File: rtl/fifo_reader_if.sv
// Source-FIFO read port and downstream flit stream bundled for fifo_reader.
interface fifo_reader_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             empty;
  logic [WIDTH-1:0] fifoData;
  logic             read;
  logic             outValid;
  logic             outReady;
  logic [WIDTH-1:0] outData;
  logic             outLast;

  modport master (
    input  empty, fifoData, outReady,
    output read, outValid, outData, outLast
  );

  modport slave (
    output empty, fifoData, outReady,
    input  read, outValid, outData, outLast
  );
endinterface

// File: rtl/fifo_reader.sv
// Drains a source FIFO into a 2-entry skid buffer and frames the flits into
// header+body packets, flagging the last flit and counting completed packets.
module fifo_reader #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned LENWIDTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  fifo_reader_if.master bus,
  output logic [15:0] pktCount
);

  localparam logic [0:0] HEAD = 1'b0;
  localparam logic [0:0] BODY = 1'b1;

  logic [1:0]          count_q, count_d;
  logic [WIDTH-1:0]    buf0_q, buf0_d;
  logic [WIDTH-1:0]    buf1_q, buf1_d;
  logic [0:0]          state_q, state_d;
  logic [LENWIDTH-1:0] rem_q, rem_d;
  logic [15:0]         pkt_q, pkt_d;

  logic                rd;
  logic                pop;
  logic                last;
  logic [LENWIDTH-1:0] hdr_len;

  // Gating with reset keeps the pop strobe low while the block is held in reset.
  assign rd      = reset & ~bus.empty & (count_q != 2'd2);
  assign pop     = bus.outValid & bus.outReady;
  assign hdr_len = buf0_q[LENWIDTH-1:0];
  assign last    = (count_q != 2'd0) &
                   (((state_q == HEAD) & (hdr_len == '0)) |
                    ((state_q == BODY) & (rem_q == LENWIDTH'(1))));

  assign bus.read     = rd;
  assign bus.outValid = (count_q != 2'd0);
  assign bus.outData  = buf0_q;
  assign bus.outLast  = last;
  assign pktCount     = pkt_q;

  always_comb begin
    buf0_d  = buf0_q;
    buf1_d  = buf1_q;
    count_d = count_q + {1'b0, rd} - {1'b0, pop};
    if (pop) begin
      buf0_d = buf1_q;
    end
    // New word lands in the slot that will be the tail after any pop this cycle.
    if (rd) begin
      if ((count_q == 2'd0) || ((count_q == 2'd1) && pop)) begin
        buf0_d = bus.fifoData;
      end else begin
        buf1_d = bus.fifoData;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    pkt_d   = pkt_q + {15'd0, pop & last};
    if (pop) begin
      case (state_q)
        HEAD: begin
          if (hdr_len != '0) begin
            state_d = BODY;
            rem_d   = hdr_len;
          end
        end
        BODY: begin
          rem_d = rem_q - LENWIDTH'(1);
          if (rem_q == LENWIDTH'(1)) begin
            state_d = HEAD;
          end
        end
        default: state_d = HEAD;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= 2'd0;
      buf0_q  <= '0;
      buf1_q  <= '0;
      state_q <= HEAD;
      rem_q   <= '0;
      pkt_q   <= 16'd0;
    end else begin
      count_q <= count_d;
      buf0_q  <= buf0_d;
      buf1_q  <= buf1_d;
      state_q <= state_d;
      rem_q   <= rem_d;
      pkt_q   <= pkt_d;
    end
  end

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader: a queue models the source FIFO and a
// per-cycle table holds hand-computed expected outputs.
module tb_fifo_reader;

  logic        clk;
  logic        reset;
  logic [15:0] pktCount;
  logic        starve;
  logic        rd_seen;
  logic [31:0] q[$];

  int unsigned n_vec;
  int unsigned n_bad;

  typedef struct {
    logic        starve;
    logic        rdy;
    logic        rd;
    logic        vld;
    logic [31:0] data;
    logic        last;
    logic [15:0] pkt;
  } row_t;

  row_t vec[$];

  fifo_reader_if #(.WIDTH(32)) bus ();

  fifo_reader #(
    .WIDTH    (32),
    .LENWIDTH (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .pktCount (pktCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add(input logic s, input logic r, input logic ed, input logic ev,
                              input logic [31:0] d, input logic el, input logic [15:0] p);
    row_t t;
    t.starve = s; t.rdy = r; t.rd = ed; t.vld = ev; t.data = d; t.last = el; t.pkt = p;
    vec.push_back(t);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive_src();
    bus.empty    = starve || (q.size() == 0);
    bus.fifoData = (q.size() != 0) ? q[0] : 32'd0;
  endtask

  // Sample read before the edge, then retire the word the DUT captured.
  task automatic tick();
    rd_seen = bus.read;
    @(posedge clk);
    #1;
    if (rd_seen && q.size() != 0) void'(q.pop_front());
    drive_src();
  endtask

  task automatic run_row(input int idx);
    row_t r;
    r = vec[idx];
    @(negedge clk);
    bus.outReady = r.rdy;
    starve       = r.starve;
    drive_src();
    #1;
    check($sformatf("row%0d read", idx), {31'd0, bus.read}, {31'd0, r.rd});
    check($sformatf("row%0d outValid", idx), {31'd0, bus.outValid}, {31'd0, r.vld});
    if (r.vld) check($sformatf("row%0d outData", idx), bus.outData, r.data);
    check($sformatf("row%0d outLast", idx), {31'd0, bus.outLast}, {31'd0, r.last});
    check($sformatf("row%0d pktCount", idx), {16'd0, pktCount}, {16'd0, r.pkt});
    tick();
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) run_row(i);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;

    // Streaming: header L=2 plus two body flits (rows 0-4)
    add(0, 1, 1, 0, 32'h0,         0, 16'd0);
    add(0, 1, 1, 1, 32'hA000_0002, 0, 16'd0);
    add(0, 1, 1, 1, 32'hB000_0001, 0, 16'd0);
    add(0, 1, 0, 1, 32'hB000_0002, 1, 16'd0);
    add(0, 1, 0, 0, 32'h0,         0, 16'd1);
    // Backpressure 5 cycles, then release (rows 5-13)
    add(0, 0, 1, 0, 32'h0,         0, 16'd1);
    add(0, 0, 1, 1, 32'hC000_0001, 0, 16'd1);
    add(0, 0, 0, 1, 32'hC000_0001, 0, 16'd1);
    add(0, 0, 0, 1, 32'hC000_0001, 0, 16'd1);
    add(0, 0, 0, 1, 32'hC000_0001, 0, 16'd1);
    add(0, 1, 0, 1, 32'hC000_0001, 0, 16'd1);
    add(0, 1, 1, 1, 32'hD000_0000, 1, 16'd1);
    add(0, 1, 0, 1, 32'hE000_0000, 1, 16'd2);
    add(0, 1, 0, 0, 32'h0,         0, 16'd3);
    // Three single-flit packets (rows 14-18)
    add(0, 1, 1, 0, 32'h0,         0, 16'd3);
    add(0, 1, 1, 1, 32'h1111_1110, 1, 16'd3);
    add(0, 1, 1, 1, 32'h2222_2220, 1, 16'd4);
    add(0, 1, 0, 1, 32'h3333_3330, 1, 16'd5);
    add(0, 1, 0, 0, 32'h0,         0, 16'd6);
    // Starve mid-body, L=3 (rows 19-27)
    add(0, 1, 1, 0, 32'h0,         0, 16'd6);
    add(0, 1, 1, 1, 32'h4000_0003, 0, 16'd6);
    add(1, 1, 0, 1, 32'h5000_0001, 0, 16'd6);
    add(1, 1, 0, 0, 32'h0,         0, 16'd6);
    add(1, 1, 0, 0, 32'h0,         0, 16'd6);
    add(0, 1, 1, 0, 32'h0,         0, 16'd6);
    add(0, 1, 1, 1, 32'h5000_0002, 0, 16'd6);
    add(0, 1, 0, 1, 32'h5000_0003, 1, 16'd6);
    add(0, 1, 0, 0, 32'h0,         0, 16'd7);
    // After a mid-packet reset (rows 28-30)
    add(0, 1, 1, 0, 32'h0,         0, 16'd0);
    add(0, 1, 0, 1, 32'h7000_0000, 1, 16'd0);
    add(0, 1, 0, 0, 32'h0,         0, 16'd1);

    // Reset held with a non-empty source
    reset        = 1'b0;
    starve       = 1'b0;
    bus.outReady = 1'b1;
    q.push_back(32'h0000_0009);
    drive_src();
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset read",     {31'd0, bus.read},     32'd0);
    check("reset outValid", {31'd0, bus.outValid}, 32'd0);
    check("reset outLast",  {31'd0, bus.outLast},  32'd0);
    check("reset pktCount", {16'd0, pktCount},     32'd0);
    q.delete();
    drive_src();
    @(posedge clk);
    #1;
    reset = 1'b1;

    q = '{32'hA000_0002, 32'hB000_0001, 32'hB000_0002};
    drive_src();
    run_rows(0, 4);

    q = '{32'hC000_0001, 32'hD000_0000, 32'hE000_0000};
    drive_src();
    run_rows(5, 13);

    q = '{32'h1111_1110, 32'h2222_2220, 32'h3333_3330};
    drive_src();
    run_rows(14, 18);

    q = '{32'h4000_0003, 32'h5000_0001, 32'h5000_0002, 32'h5000_0003};
    drive_src();
    run_rows(19, 27);

    // Reach BODY with remaining=5 (header L=6, one body flit popped)
    q = '{32'h6000_0006, 32'h6100_0001, 32'h6100_0002, 32'h6100_0003, 32'h6100_0004};
    bus.outReady = 1'b1;
    starve       = 1'b0;
    drive_src();
    repeat (3) begin
      @(negedge clk);
      #1;
      tick();
    end
    @(negedge clk);
    #1;
    check("midpkt outValid", {31'd0, bus.outValid}, 32'd1);
    check("midpkt outData",  bus.outData,           32'h6100_0002);
    check("midpkt outLast",  {31'd0, bus.outLast},  32'd0);
    check("midpkt pktCount", {16'd0, pktCount},     32'd7);
    // Asynchronous assertion between edges
    #1;
    reset = 1'b0;
    #1;
    check("async outValid", {31'd0, bus.outValid}, 32'd0);
    check("async read",     {31'd0, bus.read},     32'd0);
    check("async outLast",  {31'd0, bus.outLast},  32'd0);
    check("async pktCount", {16'd0, pktCount},     32'd0);
    @(posedge clk);
    @(negedge clk);
    #1;
    check("held read", {31'd0, bus.read}, 32'd0);
    @(posedge clk);
    #1;
    q.delete();
    q.push_back(32'h7000_0000);
    drive_src();
    reset = 1'b1;
    run_rows(28, 30);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 SHALL have parameter WIDTH, default 32, flit width in bits.
REQ-002 SHALL have parameter LENWIDTH, default 4, width of the header body-length field.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port empty  input  1  source FIFO empty flag.
REQ-006 SHALL have port fifoData  input  WIDTH  source FIFO word at tail; valid in the same cycle whenever empty=0.
REQ-007 SHALL have port read  output  1  pop strobe to the source FIFO; one word consumed per cycle asserted.
REQ-008 SHALL have port outValid  output  1  downstream flit valid.
REQ-009 SHALL have port outReady  input  1  downstream accept.
REQ-010 SHALL have port outData  output  WIDTH  downstream flit.
REQ-011 SHALL have port outLast  output  1  marks the final flit of a packet; qualified by outValid.
REQ-012 SHALL have port pktCount  output  16  number of packets fully transmitted, wrapping modulo 2^16.

Function
REQ-013 SHALL contain a 2-entry output buffer (main plus skid) with a registered occupancy count of 0..2.
REQ-014 SHALL drive read = ~empty & (count<2), combinationally from registered count and empty; never asserted when empty=1.
REQ-015 SHALL capture fifoData into the buffer tail on each rising edge where read=1; the first word appears on outData on the next cycle (1-cycle latency).
REQ-016 SHALL drive outValid = (count!=0) and outData = oldest buffered word.
REQ-017 SHALL treat a pop as outValid & outReady; on a pop the buffer advances in order, with no loss or duplication.
REQ-018 SHALL update count as count + read - pop, including a simultaneous read and pop at count=2 (read is blocked) and at count=1 (count stays 1).
REQ-019 SHALL hold outData and outLast stable while outValid=1 and outReady=0.
REQ-020 SHALL sustain one flit per cycle when empty=0 and outReady=1 continuously.
REQ-021 SHALL implement a framing FSM with states HEAD and BODY, advanced only on pops.
REQ-022 SHALL, in HEAD, treat the popped flit as a header whose bits [LENWIDTH-1:0] give the body length L.
REQ-023 SHALL, in HEAD, stay in HEAD when L=0 (single-flit packet), and otherwise load remaining=L and go to BODY.
REQ-024 SHALL, in BODY, decrement remaining on each pop and return to HEAD on the pop where remaining=1.
REQ-025 SHALL drive outLast = outValid & ((HEAD & outData[LENWIDTH-1:0]==0) | (BODY & remaining==1)).
REQ-026 SHALL increment pktCount on every pop with outLast=1, wrapping from 0xFFFF to 0.
REQ-027 SHALL support L up to 2^LENWIDTH-1 (15 by default) without overflowing remaining.

Reset
REQ-028 SHALL, while reset=0, force count=0, state=HEAD, remaining=0, pktCount=0, outValid=0, read=0 and outLast=0, independent of clk.
REQ-029 SHALL discard buffered flits on a reset asserted mid-packet; the first pop after release is treated as a header.
REQ-030 SHALL not assert read in the first cycle after reset release unless empty=0.

Verification
REQ-031 SHALL cover reset: hold reset=0 with empty=0 -> read=0, outValid=0, pktCount=0.
REQ-032 SHALL cover streaming: FIFO holds header L=2 plus 2 body flits, outReady=1 -> 3 consecutive outValid cycles, outLast on the 3rd only, pktCount=1, read high for 3 cycles.
REQ-033 SHALL cover backpressure: outReady=0 for 5 cycles with FIFO non-empty -> exactly 2 reads, count=2, read=0, and outData unchanged; on release the flits emerge in order.
REQ-034 SHALL cover single-flit packets: 3 headers with L=0 back to back -> outLast=1 on each, pktCount=3.
REQ-035 SHALL cover a FIFO starve: empty rises mid-body after the header and 1 body flit (L=3) -> outValid drops, FSM holds BODY with remaining=2, and the packet resumes correctly when empty falls.
REQ-036 SHALL cover reset mid-packet: assert reset in BODY with remaining=5 -> after release, the next flit with L=0 produces outLast=1 and pktCount=1.
